byte_mem_responder: RTL
=======================

Name: byte_mem_responder

Overview:
Memory-side end of the CPU's byte-serial memory interface. The core side serializes 32-bit addresses and write data into 8-bit beats and deserializes 8-bit read beats into words. This block performs the opposite conversions on the memory side:
- assembles the 4-beat address and write data into words;
- performs a word access to an internal array;
- streams read data back as 4 byte beats, then pulses Ready.
It serves as both the instruction-side and the data-side responder; bench and FPGA top instantiate one per side.

Parameters:
ADDR_BITS, 8, word-index width; memory depth = 2^ADDR_BITS 32-bit words
LATENCY, 2, wait cycles between last address beat and access (0 allowed)
LAT_W, 4, latency counter width; must hold LATENCY

Ports:
clk  input  1  single clock for the whole block, rising edge
rst  input  1  asynchronous, active-high reset
ReadMem  input  1  read request strobe, sampled only in IDLE
WriteMem  input  1  write request strobe, sampled only in IDLE
Addr  input  8  address beat, byte 0 (LSB) first
wData  input  8  write-data beat, sent in parallel with the Addr beats, LSB first
rData  output  8  read-data beat, LSB first
rValid  output  1  high while rData carries a valid read beat
Ready  output  1  one-cycle pulse at transaction completion
Busy  output  1  high in every state except IDLE

Behaviour:
- Reset: asynchronous, active-high.
  - State goes to IDLE; beat and latency counters go to 0.
  - rData=0, rValid=0, Ready=0, Busy=0.
  - Memory array is not cleared.
  - Reset mid-transaction aborts it. No memory write occurs unless the WRITE cycle has already been clocked.
- States: IDLE, ADDR, WAIT, RESP, WRITE, DONE.
- IDLE:
  - If WriteMem=1 (write priority over a simultaneous ReadMem): latch op=write, capture Addr beat 0 and wData beat 0, beat counter := 1, go to ADDR.
  - Otherwise, if ReadMem=1: latch op=read, capture Addr beat 0 (wData ignored), go to ADDR.
  - If neither strobe is high, stay in IDLE.
- ADDR: captures beats 1..3 on 3 consecutive cycles into byte lanes [15:8], [23:16], [31:24]. After beat 3:
  - go to WAIT if LATENCY>0;
  - else go to RESP (read) or WRITE (write).
- WAIT: counts LATENCY cycles, then goes to RESP or WRITE.
- Strobe handling: strobes are ignored outside IDLE. Deassertion or toggling mid-transaction has no effect; the transaction runs to completion.
- Address mapping: word index = addr[ADDR_BITS+1:2].
  - addr[1:0] is ignored (aligned word access only).
  - Bits above ADDR_BITS+1 are ignored, so addresses alias modulo 4*2^ADDR_BITS.
- WRITE: one cycle; mem[index] <= assembled wData word; go to DONE.
- RESP:
  - Memory word is read on RESP entry.
  - 4 cycles, rValid=1, rData = word[7:0], [15:8], [23:16], [31:24] in order.
  - Then go to DONE; rData returns to 0 and rValid to 0.
- DONE: Ready=1 for exactly one cycle, Busy=1, then IDLE. A new strobe may be accepted on the very next cycle.
- Latency from first beat (cycle T) to Ready:
  - read: T+4+LATENCY+4;
  - write: T+4+LATENCY+1.
- Read-after-write to the same address returns the new data (write completes before DONE).
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package mem_if_pkg holds:
  - state enum (IDLE, ADDR, WAIT, RESP, WRITE, DONE);
  - BYTES_PER_WORD=4;
  - beat-counter width 2;
  - op encoding (OP_READ=0, OP_WRITE=1).
- One natural sub-module: byte_deser4. It is a 4-beat LSB-first shift-in register with load/shift enable and a 2-bit beat index, instantiated twice (Addr, wData).
- Memory array, FSM and read serializer stay in the top.

Test Plan:
- Reset values: assert rst mid-cycle with no clock edge -> all outputs 0, Busy=0, immediately.
- Write then read back: write addr 0x00000010, data 0xDEADBEEF (LATENCY=2).
  - Ready arrives 7 cycles after first beat.
  - Read of 0x10 gives rValid for 4 cycles with rData EF,BE,AD,DE.
  - Ready arrives 10 cycles after first beat.
- Aliasing and alignment (ADDR_BITS=8): write 0x12345678 to 0x00000413 -> read of 0x00000010 returns 78,56,34,12.
- Simultaneous strobes: ReadMem=WriteMem=1 with data 0xCAFEF00D to 0x20 -> treated as write, no rValid beats, Ready at +7; readback of 0x20 = 0D,F0,FE,CA.
- Strobe ignored when busy: ReadMem held high continuously.
  - Exactly one transaction per IDLE visit.
  - A second transaction starts the cycle after the Ready pulse.
  - A strobe pulse during WAIT is ignored.
- Reset mid-transaction: rst during ADDR beat 2 of a write of 0x11111111 to 0x30 (prior content 0xAAAAAAAA).
  - FSM returns to IDLE.
  - Readback of 0x30 = AA,AA,AA,AA.
- LATENCY=0 build: read completes with Ready 8 cycles after first beat.

Source files
------------

// File: rtl/mem_if_pkg.sv
// Shared definitions for the byte-serial memory interface: FSM states,
// word/beat geometry and the read/write operation encoding.
package mem_if_pkg;
  localparam int BYTES_PER_WORD = 4;
  localparam int BEAT_W         = 2;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WAIT,
    RESP,
    WRITE,
    DONE
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;
endpackage

// File: rtl/byte_deser4.sv
// Four-beat LSB-first byte collector: i_load starts a new word with beat 0,
// i_shift drops the current beat into the lane selected by i_idx.
module byte_deser4
  import mem_if_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic [BEAT_W-1:0] i_idx,
  input  logic [7:0]        i_byte,
  output logic [31:0]       o_word
);
  genvar gi;
  generate
    for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
      logic [7:0] r_lane;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_lane <= 8'h00;
        end else if (i_load) begin
          r_lane <= (gi == 0) ? i_byte : 8'h00;
        end else if (i_shift && (i_idx == BEAT_W'(gi))) begin
          r_lane <= i_byte;
        end
      end

      assign o_word[8*gi +: 8] = r_lane;
    end
  endgenerate
endmodule

// File: rtl/byte_mem_responder.sv
// Memory-side responder: collects 4 address/data beats, waits LATENCY cycles,
// then writes a word or streams the read word back as 4 byte beats.
module byte_mem_responder
  import mem_if_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 2,
  parameter int LAT_W     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ReadMem,
  input  logic       WriteMem,
  input  logic [7:0] Addr,
  input  logic [7:0] wData,
  output logic [7:0] rData,
  output logic       rValid,
  output logic       Ready,
  output logic       Busy
);
  state_t            r_state, w_state_next, w_access_state;
  op_t               r_op;
  logic [BEAT_W-1:0] r_beat;
  logic [LAT_W-1:0]  r_lat;
  logic [31:0]       w_addr_word, w_wdata_word, w_addr_full, w_mem_word;
  logic [ADDR_BITS-1:0] w_index;
  logic [31:0]       r_mem [2**ADDR_BITS];
  logic [23:0]       r_shift, w_shift_next;
  logic [7:0]        r_rdata, w_rdata_next;
  logic              r_rvalid, r_ready, r_busy;
  logic              w_rvalid_next, w_ready_next, w_busy_next;
  logic              w_start, w_last_beat, w_unused_addr_bits;

  assign w_start     = (r_state == IDLE) && (ReadMem || WriteMem);
  assign w_last_beat = (r_beat == BEAT_W'(BYTES_PER_WORD - 1));

  byte_deser4 u_addr_deser (
    .clk(clk), .rst(rst), .i_load(w_start), .i_shift(r_state == ADDR),
    .i_idx(r_beat), .i_byte(Addr), .o_word(w_addr_word)
  );

  byte_deser4 u_wdata_deser (
    .clk(clk), .rst(rst), .i_load(w_start), .i_shift(r_state == ADDR),
    .i_idx(r_beat), .i_byte(wData), .o_word(w_wdata_word)
  );

  // With zero latency the read starts on the edge that captures the top address byte.
  assign w_addr_full = (r_state == ADDR) ? {Addr, w_addr_word[23:0]} : w_addr_word;
  assign w_index     = w_addr_full[ADDR_BITS+1:2];
  assign w_mem_word  = r_mem[w_index];
  assign w_unused_addr_bits = ^{w_addr_full[31:ADDR_BITS+2], w_addr_full[1:0]};

  assign w_access_state = (r_op == OP_WRITE) ? WRITE : RESP;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (ReadMem || WriteMem) w_state_next = ADDR;
      ADDR:    if (w_last_beat) w_state_next = (LATENCY > 0) ? WAIT : w_access_state;
      WAIT:    if (r_lat == LAT_W'(LATENCY - 1)) w_state_next = w_access_state;
      RESP:    if (w_last_beat) w_state_next = DONE;
      WRITE:   w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_ready_next  = (w_state_next == DONE);
    w_busy_next   = (w_state_next != IDLE);
    w_rvalid_next = (w_state_next == RESP);
    w_rdata_next  = 8'h00;
    w_shift_next  = r_shift;
    if (w_state_next == RESP) begin
      if (r_state != RESP) begin
        w_rdata_next = w_mem_word[7:0];
        w_shift_next = w_mem_word[31:8];
      end else begin
        w_rdata_next = r_shift[7:0];
        w_shift_next = {8'h00, r_shift[23:8]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_op     <= OP_READ;
      r_beat   <= '0;
      r_lat    <= '0;
      r_shift  <= '0;
      r_rdata  <= 8'h00;
      r_rvalid <= 1'b0;
      r_ready  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_shift  <= w_shift_next;
      r_rdata  <= w_rdata_next;
      r_rvalid <= w_rvalid_next;
      r_ready  <= w_ready_next;
      r_busy   <= w_busy_next;
      if (w_start) begin
        r_op   <= WriteMem ? OP_WRITE : OP_READ;
        r_beat <= BEAT_W'(1);
      end else if ((r_state == ADDR) || (r_state == RESP)) begin
        r_beat <= r_beat + BEAT_W'(1);
      end
      if (r_state == WAIT) begin
        r_lat <= (w_state_next == WAIT) ? r_lat + LAT_W'(1) : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == WRITE) begin
      r_mem[w_index] <= w_wdata_word;
    end
  end

  assign rData  = r_rdata;
  assign rValid = r_rvalid;
  assign Ready  = r_ready;
  assign Busy   = r_busy;
endmodule
